scancollide: RTL

SCANCOLLIDE -- requirements
Module: scancollide

---
 rtl/scancollide_if.sv | 32 +++
 rtl/scancollide.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/scancollide_if.sv
// scancollide_if -- raster scan / collision report bundle.
//
// Carries the per-pixel scan inputs (x, y, ball, lpad, rpad, wall), the
// consumer acknowledge (ack) and the per-frame report (valid, hit_l, hit_r,
// hit_w, hit_y, overrun).
//   master : scan source and report consumer (drives scan and ack)
//   slave  : collision detector (scancollide)
interface scancollide_if;
   logic [9:0] x;
   logic [9:0] y;
   logic       ball;
   logic       lpad;
   logic       rpad;
   logic       wall;
   logic       ack;
   logic       valid;
   logic       hit_l;
   logic       hit_r;
   logic       hit_w;
   logic [9:0] hit_y;
   logic       overrun;

   modport master (
      output x, y, ball, lpad, rpad, wall, ack,
      input  valid, hit_l, hit_r, hit_w, hit_y, overrun
   );

   modport slave (
      input  x, y, ball, lpad, rpad, wall, ack,
      output valid, hit_l, hit_r, hit_w, hit_y, overrun
   );
endinterface

// File: rtl/scancollide.sv
// scancollide -- per-frame ball/paddle/wall collision detector.
//
// Watches a raster scan and accumulates ball-vs-object overlap pixels from
// frame start (x==0,y==0) up to, but not including, (x==0,y==FRAME_Y). One
// cycle after reaching that point the frame summary is latched into the
// report registers and valid is raised; a consumer clears it with ack.
//
// Ports:
//   clk    : master clock, all logic on posedge
//   reset  : synchronous active-high reset, overrides every other input
//   bus    : scancollide_if.slave (scan inputs, ack, report outputs)
//
// Parameters:
//   FRAME_Y : line on which the report is triggered (at x==0)
//   MINPIX  : overlap pixels per frame needed to report a paddle hit (1..255)
//
// Build option:
//   SCANCOLLIDE_WALL_EN : when defined, ball/wall overlaps are accumulated
//   and reported on hit_w; otherwise the wall input is ignored and hit_w
//   stays 0.
module scancollide #(
   parameter int FRAME_Y = 480,
   parameter int MINPIX  = 2
) (
   input  logic          clk,
   input  logic          reset,
   scancollide_if.slave  bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SCAN   = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic [9:0] Y_NONE    = 10'h3FF;
   localparam logic [9:0] FRAME_Y_L = 10'(FRAME_Y);
   localparam logic [7:0] MINPIX_L  = 8'(MINPIX);

   logic [1:0] state_r;
   logic [7:0] cnt_l_r;
   logic [7:0] cnt_r_r;
   logic [9:0] acc_y_r;
   logic       load_r;
   logic       valid_r;
   logic       hit_l_r;
   logic       hit_r_r;
   logic       hit_w_r;
   logic [9:0] hit_y_r;
   logic       overrun_r;

   logic       frame_start_s;
   logic       frame_end_s;
   logic       ev_l_s;
   logic       ev_r_s;
   logic       acc_w_s;

   // Saturating pixel counter step.
   function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic inc);
      if (inc && (cnt != 8'hFF)) begin
         return cnt + 8'd1;
      end else begin
         return cnt;
      end
   endfunction

   assign frame_start_s = (bus.x == 10'd0) && (bus.y == 10'd0);
   assign frame_end_s   = (bus.x == 10'd0) && (bus.y == FRAME_Y_L);
   assign ev_l_s        = bus.ball & bus.lpad;
   assign ev_r_s        = bus.ball & bus.rpad;

`ifdef SCANCOLLIDE_WALL_EN
   logic acc_w_r;
   logic ev_w_s;

   assign ev_w_s  = bus.ball & bus.wall;
   assign acc_w_s = acc_w_r;

   // Sticky wall-overlap flag, same framing rules as the paddle counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_w_r <= 1'b0;
      end else if (frame_start_s) begin
         acc_w_r <= ev_w_s;
      end else if ((state_r == ST_SCAN) && !frame_end_s) begin
         acc_w_r <= acc_w_r | ev_w_s;
      end else begin
         acc_w_r <= acc_w_r;
      end
   end
`else
   assign acc_w_s = 1'b0;
`endif

   // Frame state machine and paddle accumulators.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_l_r <= 8'd0;
         cnt_r_r <= 8'd0;
         acc_y_r <= Y_NONE;
         load_r  <= 1'b0;
      end else if (frame_start_s) begin
         // Frame start restarts accumulation from any state; the pixel at
         // (0,0) itself already counts.
         state_r <= ST_SCAN;
         cnt_l_r <= {7'd0, ev_l_s};
         cnt_r_r <= {7'd0, ev_r_s};
         acc_y_r <= (ev_l_s | ev_r_s) ? bus.y : Y_NONE;
         load_r  <= 1'b0;
      end else begin
         load_r <= 1'b0;
         case (state_r)
            ST_SCAN: begin
               if (frame_end_s) begin
                  // The trigger pixel is not counted; report latches next cycle.
                  state_r <= ST_DONE;
                  load_r  <= 1'b1;
               end else begin
                  cnt_l_r <= sat_inc(cnt_l_r, ev_l_s);
                  cnt_r_r <= sat_inc(cnt_r_r, ev_r_s);
                  if ((ev_l_s | ev_r_s) && (acc_y_r == Y_NONE)) begin
                     acc_y_r <= bus.y;
                  end else begin
                     acc_y_r <= acc_y_r;
                  end
               end
            end
            ST_DONE: state_r <= ST_DONE;
            ST_IDLE: state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Report registers with ack handshake and overrun tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r   <= 1'b0;
         hit_l_r   <= 1'b0;
         hit_r_r   <= 1'b0;
         hit_w_r   <= 1'b0;
         hit_y_r   <= Y_NONE;
         overrun_r <= 1'b0;
      end else if (load_r) begin
         valid_r <= 1'b1;
         hit_l_r <= (cnt_l_r >= MINPIX_L);
         hit_r_r <= (cnt_r_r >= MINPIX_L);
         hit_w_r <= acc_w_s;
         hit_y_r <= acc_y_r;
         // Overwriting an unacknowledged report flags overrun; an ack in the
         // same cycle consumes the old report, so overrun is left alone.
         if (valid_r && !bus.ack) begin
            overrun_r <= 1'b1;
         end else begin
            overrun_r <= overrun_r;
         end
      end else if (valid_r && bus.ack) begin
         valid_r   <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         valid_r   <= valid_r;
         overrun_r <= overrun_r;
      end
   end

   assign bus.valid   = valid_r;
   assign bus.hit_l   = hit_l_r;
   assign bus.hit_r   = hit_r_r;
   assign bus.hit_w   = hit_w_r;
   assign bus.hit_y   = hit_y_r;
   assign bus.overrun = overrun_r;

endmodule
